// File: rtl/pos_sync_bank_if.sv
// Bus bundle between the UART position decoder (master) and the frame-synchronised
// position bank (slave).
interface pos_sync_bank_if #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]       i_valid;
    logic [CHANNELS*WIDTH-1:0] i_data;
    logic                      i_frame_start;
    logic                      i_clear_overrun;
    logic [CHANNELS*WIDTH-1:0] o_pos;
    logic [CHANNELS-1:0]       o_updated;
    logic [CHANNELS-1:0]       o_overrun;

    modport master (
        output i_valid, i_data, i_frame_start, i_clear_overrun,
        input  o_pos, o_updated, o_overrun
    );

    modport slave (
        input  i_valid, i_data, i_frame_start, i_clear_overrun,
        output o_pos, o_updated, o_overrun
    );
endinterface

// File: rtl/pos_sync_bank.sv
// Per-channel delay pipeline, playfield clamp and pending register; positions are
// committed to the render side only on a frame boundary so paddles never tear.
module pos_sync_bank #(
    parameter int WIDTH     = 10,
    parameter int CHANNELS  = 2,
    parameter int STAGES    = 2,
    parameter int MAX_POS   = 479,
    parameter int RESET_POS = 240
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    pos_sync_bank_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_POS);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_POS);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [STAGES-1:0] pipe_valid_reg;
        logic [WIDTH-1:0]  pipe_data_reg [STAGES];
        logic              tail_valid;
        logic [WIDTH-1:0]  tail_clamped;
        logic [WIDTH-1:0]  pending_reg;
        logic              pending_flag_reg;
        logic [WIDTH-1:0]  pos_reg;
        logic              updated_reg;
        logic              overrun_reg;

        assign tail_valid   = pipe_valid_reg[STAGES-1];
        assign tail_clamped = (pipe_data_reg[STAGES-1] > MAX_W) ? MAX_W
                                                                : pipe_data_reg[STAGES-1];

        // Valid travels with its data and the pipe never stalls, so bubbles pass through.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                pipe_valid_reg <= '0;
                for (int s = 0; s < STAGES; s++) begin
                    pipe_data_reg[s] <= '0;
                end
            end else begin
                pipe_valid_reg[0] <= bus.i_valid[gi];
                pipe_data_reg[0]  <= bus.i_data[gi*WIDTH +: WIDTH];
                for (int s = 1; s < STAGES; s++) begin
                    pipe_valid_reg[s] <= pipe_valid_reg[s-1];
                    pipe_data_reg[s]  <= pipe_data_reg[s-1];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                pending_reg      <= '0;
                pending_flag_reg <= 1'b0;
                pos_reg          <= RESET_W;
                updated_reg      <= 1'b0;
                overrun_reg      <= 1'b0;
            end else begin
                updated_reg <= 1'b0;
                if (bus.i_clear_overrun) begin
                    overrun_reg <= 1'b0;
                end
                if (bus.i_frame_start) begin
                    // A word arriving on the boundary itself wins over the older pending one.
                    if (tail_valid) begin
                        pos_reg          <= tail_clamped;
                        pending_flag_reg <= 1'b0;
                        updated_reg      <= 1'b1;
                    end else if (pending_flag_reg) begin
                        pos_reg          <= pending_reg;
                        pending_flag_reg <= 1'b0;
                        updated_reg      <= 1'b1;
                    end
                end else if (tail_valid) begin
                    pending_reg      <= tail_clamped;
                    pending_flag_reg <= 1'b1;
                    if (pending_flag_reg) begin
                        overrun_reg <= 1'b1;
                    end
                end
            end
        end

        assign bus.o_pos[gi*WIDTH +: WIDTH] = pos_reg;
        assign bus.o_updated[gi]            = updated_reg;
        assign bus.o_overrun[gi]            = overrun_reg;
    end
endmodule

// File: tb/tb_pos_sync_bank.sv
// Directed bench for pos_sync_bank: stimulus pushes expected commits into a queue,
// a negedge monitor pops them when o_updated fires and watches o_pos stability.
module tb_pos_sync_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic mon_en = 1'b0;
    logic [9:0] exp_pos0 = 10'd240;
    logic [9:0] exp_pos1 = 10'd240;

    typedef struct {
        int         cyc;
        logic [1:0] mask;
        logic [9:0] p0;
        logic [9:0] p1;
    } exp_t;
    exp_t sb[$];

    pos_sync_bank_if #(.WIDTH(10), .CHANNELS(2)) bus ();

    pos_sync_bank #(
        .WIDTH(10), .CHANNELS(2), .STAGES(2), .MAX_POS(479), .RESET_POS(240)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mon_en) begin
            if (bus.o_updated != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_update", 64'(bus.o_updated), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("update_cycle", 64'(cyc), 64'(e.cyc));
                    check("update_mask", 64'(bus.o_updated), 64'(e.mask));
                    check("commit_pos_ch0", 64'(bus.o_pos[9:0]), 64'(e.p0));
                    check("commit_pos_ch1", 64'(bus.o_pos[19:10]), 64'(e.p1));
                    exp_pos0 = e.p0;
                    exp_pos1 = e.p1;
                end
            end else begin
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    check("missing_update", 64'd0, 64'(e.mask));
                    exp_pos0 = e.p0;
                    exp_pos1 = e.p1;
                end
                check("pos_stable_ch0", 64'(bus.o_pos[9:0]), 64'(exp_pos0));
                check("pos_stable_ch1", 64'(bus.o_pos[19:10]), 64'(exp_pos1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [1:0] v, input logic [9:0] d0, input logic [9:0] d1);
        bus.i_valid = v;
        bus.i_data  = {d1, d0};
        tick();
        bus.i_valid = 2'b00;
        bus.i_data  = '0;
    endtask

    task automatic frame(input logic upd, input logic [1:0] mask,
                         input logic [9:0] p0, input logic [9:0] p1);
        exp_t e;
        if (upd) begin
            e.cyc = cyc + 1; e.mask = mask; e.p0 = p0; e.p1 = p1;
            sb.push_back(e);
        end
        bus.i_frame_start = 1'b1;
        tick();
        bus.i_frame_start = 1'b0;
    endtask

    task automatic clear_pulse();
        bus.i_clear_overrun = 1'b1;
        tick();
        bus.i_clear_overrun = 1'b0;
    endtask

    initial begin
        bus.i_valid = 2'b00;
        bus.i_data = '0;
        bus.i_frame_start = 1'b0;
        bus.i_clear_overrun = 1'b0;

        // Reset and idle with frame pulses
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        mon_en = 1'b1;
        check("reset_pos", 64'(bus.o_pos), 64'({10'd240, 10'd240}));
        check("reset_updated", 64'(bus.o_updated), 64'd0);
        check("reset_overrun", 64'(bus.o_overrun), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(4);
            frame(1'b0, 2'b00, 10'd0, 10'd0);
        end

        // Basic commit on ch0
        send(2'b01, 10'd100, 10'd0);
        idle(4);
        frame(1'b1, 2'b01, 10'd100, 10'd240);
        idle(3);

        // Clamp and boundary on ch1
        send(2'b10, 10'd0, 10'd1000);
        idle(2);
        frame(1'b1, 2'b10, 10'd100, 10'd479);
        send(2'b10, 10'd0, 10'd479);
        idle(2);
        frame(1'b1, 2'b10, 10'd100, 10'd479);
        send(2'b10, 10'd0, 10'd0);
        idle(2);
        frame(1'b1, 2'b10, 10'd100, 10'd0);

        // Overrun on ch1: second tail arrives while the first is still pending
        send(2'b10, 10'd0, 10'd50);
        send(2'b10, 10'd0, 10'd60);
        idle(1);
        check("overrun_not_yet", 64'(bus.o_overrun), 64'b00);
        idle(1);
        check("overrun_set", 64'(bus.o_overrun), 64'b10);
        frame(1'b1, 2'b10, 10'd100, 10'd60);
        idle(1);
        check("overrun_sticky", 64'(bus.o_overrun), 64'b10);
        clear_pulse();
        check("overrun_cleared", 64'(bus.o_overrun), 64'b00);

        // Clear coinciding with a new overrun event: set wins
        send(2'b01, 10'd1, 10'd0);
        send(2'b01, 10'd2, 10'd0);
        idle(1);
        clear_pulse();
        check("overrun_set_beats_clear", 64'(bus.o_overrun), 64'b01);
        frame(1'b1, 2'b01, 10'd2, 10'd60);
        clear_pulse();
        check("overrun_cleared2", 64'(bus.o_overrun), 64'b00);

        // Bypass: frame_start exactly when the tail is valid
        send(2'b01, 10'd200, 10'd0);
        idle(1);
        frame(1'b1, 2'b01, 10'd200, 10'd60);
        check("bypass_no_overrun", 64'(bus.o_overrun), 64'b00);

        // Early frame: data not yet at tail, commits on the following frame
        send(2'b01, 10'd201, 10'd0);
        frame(1'b0, 2'b00, 10'd0, 10'd0);
        idle(2);
        frame(1'b1, 2'b01, 10'd201, 10'd60);

        // Bypass with pending set: pending 210 dropped silently, 220 committed
        send(2'b01, 10'd210, 10'd0);
        send(2'b01, 10'd220, 10'd0);
        idle(1);
        frame(1'b1, 2'b01, 10'd220, 10'd60);
        check("bypass_pending_no_overrun", 64'(bus.o_overrun), 64'b00);
        idle(2);
        frame(1'b0, 2'b00, 10'd0, 10'd0);

        // Reset mid-flight discards the in-flight word
        send(2'b01, 10'd300, 10'd0);
        rst_n = 1'b0;
        tick();
        exp_pos0 = 10'd240;
        exp_pos1 = 10'd240;
        rst_n = 1'b1;
        idle(2);
        frame(1'b0, 2'b00, 10'd0, 10'd0);
        check("midreset_updated", 64'(bus.o_updated), 64'd0);
        idle(1);
        check("midreset_pos", 64'(bus.o_pos), 64'({10'd240, 10'd240}));
        check("midreset_overrun", 64'(bus.o_overrun), 64'd0);

        // Recovery after reset
        send(2'b10, 10'd0, 10'd123);
        idle(1);
        frame(1'b1, 2'b10, 10'd240, 10'd123);
        idle(4);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pos_sync_bank.md
# pos_sync_bank

Multi-channel, parametrised position synchroniser for the pong renderer. It takes position words from the UART decode path and delays each one through a configurable flop pipeline. Each word is clamped to the playfield and held as pending until the next frame boundary, then committed to the render side. Because positions change only between frames, paddles never tear mid-frame. It sits between the UART command decoder and the paddle/ball drawing logic, all on the single system clock.

## Interface
Parameters:
- WIDTH, 10: bits per position word.
- CHANNELS, 2: number of independent position channels (e.g. left/right paddle).
- STAGES, 2: pipeline flop depth per channel, ≥1.
- MAX_POS, 479: clamp ceiling; MAX_POS < 2^WIDTH.
- RESET_POS, 240: value of every o_pos channel after reset; RESET_POS ≤ MAX_POS.

Ports:
- i_clk, input, 1: system clock; all logic on rising edge.
- i_rst_n, input, 1: reset, synchronous, active-low.
- i_valid, input, CHANNELS: per-channel data strobe.
- i_data, input, CHANNELS*WIDTH: channel k at bits [k*WIDTH +: WIDTH].
- i_frame_start, input, 1: one-cycle pulse at the frame boundary (blanking start).
- i_clear_overrun, input, 1: clears all overrun flags.
- o_pos, output, CHANNELS*WIDTH: committed positions, same packing as i_data.
- o_updated, output, CHANNELS: one-cycle pulse when a channel's o_pos changes by commit.
- o_overrun, output, CHANNELS: sticky flag; a pending value was overwritten before commit.

## Operation
- Per channel, a STAGES-deep shift pipeline carries {valid, data} and advances every cycle, whatever the value of valid. Valid travels with its data, so bubbles do not stall the pipeline.
- Tail of the pipeline (last stage) in cycle c holds the input of cycle c−STAGES. The tail data is clamped: value > MAX_POS becomes MAX_POS, otherwise it passes unchanged.
- Pending register and pending flag, per channel:
  - Tail valid and no i_frame_start: pending ← clamped tail, and the flag is set.
  - If the flag was already set in that case, o_overrun[k] ← 1. Latest value wins.
- On i_frame_start in cycle f, per channel:
  - Tail valid in f: o_pos ← clamped tail (bypass, priority over pending). The flag is cleared and o_updated[k] pulses.
  - Else, flag set: o_pos ← pending. The flag is cleared and o_updated[k] pulses.
  - Else: o_pos holds and o_updated[k] stays 0.
- Overrun is not raised when the tail and i_frame_start coincide with the flag set. The bypass value is committed and the old pending value is discarded silently.
- i_clear_overrun clears all o_overrun bits. When it coincides with a new overrun event, the set wins for that channel.
- Channels are fully independent. Only i_frame_start, i_clear_overrun and reset are shared.
- Reset (i_rst_n low at a clock edge) gives:
  - all pipeline valids 0 and all pending flags 0;
  - o_pos = RESET_POS per channel, o_updated = 0, o_overrun = 0.
- Reset mid-operation discards all in-flight and pending data.

## Timing
- i_valid in cycle t gives a tail-valid in cycle t+STAGES.
- The earliest commit is i_frame_start in t+STAGES, with o_pos new and o_updated high in t+STAGES+1.
- i_frame_start in cycle f gives registered outputs in f+1. o_updated is high for exactly that cycle.
- A frame_start before the data reaches the tail does not commit that data; the data stays pending for the next frame.
- An overrun event with tail in cycle c sets o_overrun in c+1.
- o_pos never changes except in the cycle after i_frame_start, or on reset.
- STAGES=1 is legal (single flop); latency scales linearly with STAGES.

## Test plan
All scenarios use WIDTH=10, CHANNELS=2, STAGES=2, MAX_POS=479, RESET_POS=240.
- Reset: i_rst_n low 2 cycles, then high → o_pos = {240,240}, o_updated = 0, o_overrun = 0. No change over 20 idle cycles, including frame_start pulses.
- Basic commit: ch0 i_valid with 100 in cycle 5, i_frame_start in cycle 10 → o_pos[ch0] = 100 and o_updated = 2'b01 in cycle 11 only. ch1 stays 240.
- Clamp and boundary: ch1 data 1000, then 479, each committed on a separate frame → o_pos[ch1] = 479 both times. Data 0 → 0.
- Overrun:
  - ch1 valid 50 in cycle 3, 60 in cycle 4, frame_start in cycle 9 → o_overrun[1] = 1 from cycle 7, o_pos[ch1] = 60 in cycle 10.
  - i_clear_overrun in cycle 12 → o_overrun = 0 in cycle 13.
- Bypass and early frame:
  - ch0 valid 200 in cycle 20, frame_start in cycle 22 → o_pos = 200 in cycle 23, o_overrun stays 0.
  - Repeat with frame_start in cycle 21 → no update. The value commits at the next frame_start.
- Reset mid-flight: ch0 valid 300 in cycle 30, i_rst_n low in cycle 31, frame_start in cycle 35 → o_pos[ch0] = 240, o_updated = 0.
